// File: rtl/digi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digi_pkg : header field helpers, event-builder state encoding, clog2 |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package digi_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_BC_W  = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      TRL  = 2'd3
   } state_t;

   // Header layout is {marker, channel field, BC}; the marker sits in the MSB.
   function automatic int marker_pos(input int width);
      return width - 1;
   endfunction

   function automatic int chan_field_w(input int width, input int bc_w);
      return width - 1 - bc_w;
   endfunction

   // Returns at least 1 so single-entry indices still get a real bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : circular first-set search of CHAN requests from pointer |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module rr_arbiter
   import digi_pkg::*;
#(
   parameter int CHAN = 8,
   parameter int IW   = clog2(CHAN)
) (
   input  logic [CHAN-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [IW-1:0]   o_idx,
   output logic            o_valid
);

   int c;

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      c       = 0;
      for (int k = 0; k < CHAN; k++) begin
         c = (int'(i_ptr) + k) % CHAN;
         if (!o_valid && i_req[c]) begin
            o_valid = 1'b1;
            o_idx   = IW'(c);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered read data and count    |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_rd;

   assign o_full  = (cnt_q == FULL_CNT);
   assign o_empty = (cnt_q == '0);
   assign o_count = cnt_q;
   assign o_rdata = rdata_q;
   assign do_rd   = i_rd && !o_empty;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      if (i_wr) wp_d = wp_q + 1'b1;
      if (do_rd) begin
         rp_d    = rp_q + 1'b1;
         rdata_d = mem[rp_q];
      end
      case ({i_wr, do_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage needs no reset: flushing the pointers empties the FIFO.
   always_ff @(posedge clk) begin
      if (i_wr) mem[wp_q] <= i_wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_wr && o_full));

endmodule
`default_nettype wire

// File: rtl/digi_many_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digi_many_rr : round-robin multi-channel event builder into a FIFO;  |
// |                macro TRAILER_EN appends an XOR trailer per event     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module digi_many_rr
   import digi_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CHAN    = 8,
   parameter int SIZE    = 8,
   parameter int BC_W    = DEF_BC_W,
   parameter int FIFO_AW = 10
) (
   input  logic                  CK50,
   input  logic                  RST,
   input  logic [CHAN-1:0]       TRIGGER,
   input  logic [SIZE-1:0]       HOWMANY,
   input  logic [WIDTH*CHAN-1:0] CH_DOUT,
   output logic [CHAN-1:0]       CH_RD,
   input  logic                  ZYNQ_RD_REQUEST,
   output logic [WIDTH-1:0]      DOUT,
   output logic                  GLBL_FULL,
   output logic                  GLBL_EMPTY,
   output logic [FIFO_AW:0]      FIFO_COUNT,
   output logic [7:0]            LOST_CNT,
   output logic                  BUSY
);

   localparam int CHF_W = chan_field_w(WIDTH, BC_W);
   localparam int IW    = clog2(CHAN);
   localparam int DEPTH = 2**FIFO_AW;
`ifdef TRAILER_EN
   localparam int OVH   = 3;
`else
   localparam int OVH   = 2;
`endif

   state_t          state_q, state_d;
   logic [BC_W-1:0] bc_q, bc_d, ets_q, ets_d;
   logic [BC_W-1:0] ts_q [CHAN];
   logic [BC_W-1:0] ts_d [CHAN];
   logic [CHAN-1:0] trig_q, pend_q, pend_d;
   logic [IW-1:0]   ptr_q, ptr_d, chan_q, chan_d;
   logic [SIZE-1:0] hm_q, hm_d, rdn_q, rdn_d, wrn_q, wrn_d;
   logic [7:0]      lost_q, lost_d;
`ifdef TRAILER_EN
   logic [WIDTH-1:0] xor_q, xor_d;
`endif

   logic [CHAN-1:0]  rise, clr, drop;
   logic [IW-1:0]    arb_idx;
   logic             arb_valid, space_ok, grant, fifo_wr;
   logic [WIDTH-1:0] fifo_wdata, sample;
   int               nlost;

   rr_arbiter #(.CHAN(CHAN), .IW(IW)) u_arb (
      .i_req   (pend_q),
      .i_ptr   (ptr_q),
      .o_idx   (arb_idx),
      .o_valid (arb_valid)
   );

   sync_fifo #(.WIDTH(WIDTH), .AW(FIFO_AW)) u_fifo (
      .clk     (CK50),
      .rst     (RST),
      .i_wr    (fifo_wr),
      .i_wdata (fifo_wdata),
      .i_rd    (ZYNQ_RD_REQUEST),
      .o_rdata (DOUT),
      .o_full  (GLBL_FULL),
      .o_empty (GLBL_EMPTY),
      .o_count (FIFO_COUNT)
   );

   // Whole-event space check keeps writes unblocked for the event's duration.
   assign rise     = TRIGGER & ~trig_q;
   assign space_ok = (DEPTH - int'(FIFO_COUNT)) >= (int'(HOWMANY) + OVH);
   assign grant    = (state_q == IDLE) && arb_valid && space_ok;
   assign sample   = CH_DOUT[chan_q*WIDTH +: WIDTH];
   assign BUSY     = (state_q != IDLE);
   assign LOST_CNT = lost_q;

   always_comb begin
      CH_RD = '0;
      if ((state_q == HDR && hm_q != '0) || (state_q == DATA && rdn_q < hm_q))
         CH_RD[chan_q] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      bc_d       = bc_q + 1'b1;
      ptr_d      = ptr_q;
      chan_d     = chan_q;
      hm_d       = hm_q;
      ets_d      = ets_q;
      rdn_d      = rdn_q;
      wrn_d      = wrn_q;
      clr        = '0;
      fifo_wr    = 1'b0;
      fifo_wdata = '0;
`ifdef TRAILER_EN
      xor_d      = xor_q;
`endif
      case (state_q)
         IDLE: if (grant) begin
            chan_d       = arb_idx;
            hm_d         = HOWMANY;
            ets_d        = ts_q[arb_idx];
            clr[arb_idx] = 1'b1;
            ptr_d        = (arb_idx == IW'(CHAN-1)) ? '0 : arb_idx + 1'b1;
            rdn_d        = '0;
            wrn_d        = '0;
`ifdef TRAILER_EN
            xor_d        = '0;
`endif
            state_d      = HDR;
         end
         HDR: begin
            fifo_wr    = 1'b1;
            fifo_wdata = {1'b1, CHF_W'(chan_q), ets_q};
            if (hm_q != '0) begin
               rdn_d   = 1;
               state_d = DATA;
            end else begin
`ifdef TRAILER_EN
               state_d = TRL;
`else
               state_d = IDLE;
`endif
            end
         end
         DATA: begin
            fifo_wr    = 1'b1;
            fifo_wdata = sample;
            wrn_d      = wrn_q + 1'b1;
            if (rdn_q < hm_q) rdn_d = rdn_q + 1'b1;
`ifdef TRAILER_EN
            xor_d      = xor_q ^ sample;
            if (wrn_q == hm_q - 1'b1) state_d = TRL;
`else
            if (wrn_q == hm_q - 1'b1) state_d = IDLE;
`endif
         end
`ifdef TRAILER_EN
         TRL: begin
            fifo_wr    = 1'b1;
            fifo_wdata = xor_q;
            state_d    = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // A rise on the channel being granted this cycle becomes a fresh pending event.
   always_comb begin
      drop   = rise & pend_q & ~clr;
      pend_d = (pend_q & ~clr) | rise;
      ts_d   = ts_q;
      nlost  = int'(lost_q);
      for (int i = 0; i < CHAN; i++) begin
         if (rise[i] && !drop[i]) ts_d[i] = bc_q;
         if (drop[i]) nlost++;
      end
      lost_d = (nlost > 255) ? 8'hFF : 8'(nlost);
   end

   always_ff @(posedge CK50 or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         bc_q    <= '0;
         trig_q  <= '0;
         pend_q  <= '0;
         ptr_q   <= '0;
         chan_q  <= '0;
         hm_q    <= '0;
         rdn_q   <= '0;
         wrn_q   <= '0;
         ets_q   <= '0;
         lost_q  <= '0;
         for (int i = 0; i < CHAN; i++) ts_q[i] <= '0;
`ifdef TRAILER_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         bc_q    <= bc_d;
         trig_q  <= TRIGGER;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         chan_q  <= chan_d;
         hm_q    <= hm_d;
         rdn_q   <= rdn_d;
         wrn_q   <= wrn_d;
         ets_q   <= ets_d;
         lost_q  <= lost_d;
         for (int i = 0; i < CHAN; i++) ts_q[i] <= ts_d[i];
`ifdef TRAILER_EN
         xor_q   <= xor_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_digi_many_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_digi_many_rr : scoreboard bench for digi_many_rr (16-deep FIFO)   |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_digi_many_rr;

   localparam int WIDTH = 16, CHAN = 8, SIZE = 8, BC_W = 12, FIFO_AW = 4, DEPTH = 16;
`ifdef TRAILER_EN
   localparam int TRL_N = 1;
`else
   localparam int TRL_N = 0;
`endif

   logic                  CK50 = 1'b0;
   logic                  RST = 1'b1;
   logic [CHAN-1:0]       TRIGGER = '0;
   logic [SIZE-1:0]       HOWMANY = '0;
   logic [WIDTH*CHAN-1:0] CH_DOUT = '0;
   logic [CHAN-1:0]       CH_RD;
   logic                  ZYNQ_RD_REQUEST = 1'b0;
   logic [WIDTH-1:0]      DOUT;
   logic                  GLBL_FULL, GLBL_EMPTY, BUSY;
   logic [FIFO_AW:0]      FIFO_COUNT;
   logic [7:0]            LOST_CNT;

   digi_many_rr #(.WIDTH(WIDTH), .CHAN(CHAN), .SIZE(SIZE), .BC_W(BC_W), .FIFO_AW(FIFO_AW)) dut (
      .CK50(CK50), .RST(RST), .TRIGGER(TRIGGER), .HOWMANY(HOWMANY), .CH_DOUT(CH_DOUT),
      .CH_RD(CH_RD), .ZYNQ_RD_REQUEST(ZYNQ_RD_REQUEST), .DOUT(DOUT), .GLBL_FULL(GLBL_FULL),
      .GLBL_EMPTY(GLBL_EMPTY), .FIFO_COUNT(FIFO_COUNT), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
   );

   always #10 CK50 = ~CK50;

   int               n_checks = 0, n_fail = 0;
   logic [WIDTH-1:0] exp_q [$];
   int               exp_k [CHAN];
   int               pulses [CHAN];
   int               rdk [CHAN];
   logic [CHAN-1:0]  rd_seen = '0;
   logic [BC_W-1:0]  bc_m;
   logic             rd_fire;
   int               max_cnt = 0;

   function automatic logic [WIDTH-1:0] sample_val(input int c, input int k);
      logic [3:0] cc;
      cc = 4'(c) ^ 4'h2;
      return {4'hA, cc, 8'(k)};
   endfunction

   // Reference bunch-crossing count, used to predict header timestamps.
   always @(posedge CK50 or posedge RST)
      if (RST) bc_m <= '0; else bc_m <= bc_m + 1'b1;

   // Channel model: data appears the cycle after a CH_RD pulse.
   always @(negedge CK50) rd_seen <= CH_RD;
   always @(posedge CK50 or posedge RST) begin
      if (RST) begin
         CH_DOUT <= '0;
         for (int c = 0; c < CHAN; c++) begin rdk[c] <= 0; pulses[c] <= 0; end
      end else begin
         for (int c = 0; c < CHAN; c++) if (rd_seen[c]) begin
            CH_DOUT[c*WIDTH +: WIDTH] <= sample_val(c, rdk[c] + 1);
            rdk[c]    <= rdk[c] + 1;
            pulses[c] <= pulses[c] + 1;
         end
      end
   end

   always @(negedge CK50) if (int'(FIFO_COUNT) > max_cnt) max_cnt <= int'(FIFO_COUNT);

   // Monitor: every accepted FIFO read is compared against the scoreboard.
   always @(posedge CK50 or posedge RST)
      if (RST) rd_fire <= 1'b0; else rd_fire <= ZYNQ_RD_REQUEST && !GLBL_EMPTY;

   always @(negedge CK50) begin
      logic [WIDTH-1:0] e;
      if (rd_fire && !RST) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL dout_unexpected: got %h, no word expected", DOUT);
         end else begin
            e = exp_q.pop_front();
            if (DOUT !== e) begin
               n_fail++;
               $display("FAIL dout_word: got %h expected %h", DOUT, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CK50);
   endtask

   task automatic do_reset();
      @(negedge CK50);
      RST = 1'b1;
      exp_q.delete();
      for (int c = 0; c < CHAN; c++) exp_k[c] = 0;
      tick(3);
      RST = 1'b0;
   endtask

   task automatic pulse_trig(input logic [CHAN-1:0] m);
      TRIGGER = TRIGGER | m;
      @(negedge CK50);
      TRIGGER = TRIGGER & ~m;
      @(negedge CK50);
   endtask

   task automatic push_event(input int c, input logic [BC_W-1:0] ts, input int hm);
      logic [WIDTH-1:0] x, v;
      x = '0;
      exp_q.push_back({1'b1, 3'(c), ts});
      for (int k = 1; k <= hm; k++) begin
         v = sample_val(c, exp_k[c] + k);
         exp_q.push_back(v);
         x = x ^ v;
      end
      exp_k[c] += hm;
      if (TRL_N == 1) exp_q.push_back(x);
   endtask

   task automatic wait_settle(input string name);
      int idle, t;
      idle = 0; t = 0;
      while (idle < 4 && t < 3000) begin
         @(negedge CK50);
         idle = BUSY ? 0 : idle + 1;
         t++;
      end
      if (idle < 4) begin
         n_checks++; n_fail++;
         $display("FAIL %s_settle: still busy after %0d cycles", name, t);
      end
   endtask

   task automatic drain(input string name, input bit check_left);
      int t;
      t = 0;
      while (!GLBL_EMPTY && t < 200) begin
         ZYNQ_RD_REQUEST = 1'b1;
         @(negedge CK50);
         t++;
      end
      ZYNQ_RD_REQUEST = 1'b0;
      tick(2);
      if (check_left) check({name, "_words_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [BC_W-1:0] ts;
      int p0, p1, t;

      do_reset();
      check("rst_ch_rd", CH_RD, 0);
      check("rst_dout", DOUT, 0);
      check("rst_empty", GLBL_EMPTY, 1);
      check("rst_full", GLBL_FULL, 0);
      check("rst_count", FIFO_COUNT, 0);
      check("rst_lost", LOST_CNT, 0);
      check("rst_busy", BUSY, 0);

      // Single event: channel 2, HOWMANY=4, rising at BC=0x010
      HOWMANY = 8'd4;
      t = 0;
      while (bc_m !== 12'h010 && t < 5000) begin @(negedge CK50); t++; end
      exp_q.push_back(16'hA010);
      exp_q.push_back(16'hA001); exp_q.push_back(16'hA002);
      exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
      if (TRL_N == 1) exp_q.push_back(16'h0004);
      exp_k[2] = 4;
      pulse_trig(8'h04);
      wait_settle("single");
      check("single_rd_pulses", pulses[2], 4);
      check("single_count", FIFO_COUNT, 5 + TRL_N);
      drain("single", 1'b1);

      // Simultaneous rises on 0,5,7 from pointer 0, then 0 and 6 after wrap
      do_reset();
      HOWMANY = 8'd2;
      ts = bc_m;
      push_event(0, ts, 2); push_event(5, ts, 2); push_event(7, ts, 2);
      pulse_trig(8'b1010_0001);
      wait_settle("simul_a");
      check("simul_a_count", FIFO_COUNT, 3 * (3 + TRL_N));
      drain("simul_a", 1'b1);
      ts = bc_m;
      push_event(0, ts, 2); push_event(6, ts, 2);
      pulse_trig(8'b0100_0001);
      wait_settle("simul_b");
      drain("simul_b", 1'b1);

      // Backpressure: a 12-sample event cannot be granted until space exists
      HOWMANY = 8'd12;
      push_event(3, bc_m, 12);
      pulse_trig(8'h08);
      wait_settle("bp_first");
      check("bp_first_count", FIFO_COUNT, 13 + TRL_N);
      p0 = pulses[4]; p1 = pulses[1];
      ts = bc_m;
      push_event(4, ts, 12); push_event(1, ts, 12);
      pulse_trig(8'h12);
      tick(20);
      check("bp_stall_busy", BUSY, 0);
      check("bp_stall_count", FIFO_COUNT, 13 + TRL_N);
      check("bp_stall_full", GLBL_FULL, 0);
      check("bp_stall_pulses", pulses[4] - p0, 0);
      repeat (3) pulse_trig(8'h02);
      check("lost_three", LOST_CNT, 3);
      ZYNQ_RD_REQUEST = 1'b1;
      tick(12 + TRL_N);
      ZYNQ_RD_REQUEST = 1'b0;
      wait_settle("bp_grant");
      check("bp_ch4_pulses", pulses[4] - p0, 12);
      drain("bp_a", 1'b0);
      wait_settle("bp_ch1");
      drain("bp_b", 1'b1);
      check("bp_ch1_pulses", pulses[1] - p1, 12);
      n_checks++;
      if (max_cnt > DEPTH) begin
         n_fail++;
         $display("FAIL fifo_max_count: got %0d limit %0d", max_cnt, DEPTH);
      end

      // HOWMANY=0: header only (plus zero trailer), no channel reads
      HOWMANY = 8'd0;
      p0 = pulses[6];
      push_event(6, bc_m, 0);
      pulse_trig(8'h40);
      wait_settle("hm0");
      check("hm0_pulses", pulses[6] - p0, 0);
      check("hm0_count", FIFO_COUNT, 1 + TRL_N);
      drain("hm0", 1'b1);

      // Lost counter saturation: channel 1 stays pending (event never fits)
      HOWMANY = 8'd255;
      pulse_trig(8'h02);
      for (int i = 0; i < 300; i++) pulse_trig(8'h02);
      check("lost_saturate", LOST_CNT, 255);
      check("lost_busy", BUSY, 0);
      check("lost_empty", GLBL_EMPTY, 1);

      // Reset asserted in the middle of DATA
      do_reset();
      HOWMANY = 8'd10;
      pulse_trig(8'h20);
      t = 0;
      while (!BUSY && t < 50) begin @(negedge CK50); t++; end
      tick(3);
      check("midrst_busy_before", BUSY, 1);
      RST = 1'b1;
      exp_q.delete();
      for (int c = 0; c < CHAN; c++) exp_k[c] = 0;
      #1;
      check("midrst_ch_rd", CH_RD, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_empty", GLBL_EMPTY, 1);
      check("midrst_count", FIFO_COUNT, 0);
      check("midrst_dout", DOUT, 0);
      check("midrst_full", GLBL_FULL, 0);
      tick(2);
      RST = 1'b0;
      HOWMANY = 8'd3;
      push_event(5, bc_m, 3);
      pulse_trig(8'h20);
      wait_settle("post_rst");
      check("post_rst_pulses", pulses[5], 3);
      check("post_rst_count", FIFO_COUNT, 4 + TRL_N);
      drain("post_rst", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
